// File: rtl/life_engine.sv
// life_engine: Conway's Game of Life on a small bounded board.
// The displayed board (disp) is held stable while the next generation is built
// one cell per cycle into a scratch board (work), then copied across in one cycle.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | counting frame ticks (when run=1) toward the next generation
// ST_COMPUTE | writing work[idx] = next state of cell idx, one cell per cycle
// ST_COMMIT  | disp <= work, gen_count++, gen_done pulse
module life_engine #(
  parameter int BIT_WIDTH      = 3,
  parameter int BIT_HEIGHT     = 3,
  parameter int FRAMES_PER_GEN = 60,
  parameter logic [(1 << (BIT_WIDTH + BIT_HEIGHT)) - 1:0] SEED = 64'h0000_0000_0000_0008
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            run,
  input  logic                            load,
  input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] rd_addr,
  output logic                            rd_data,
  output logic                            busy,
  output logic                            gen_done,
  output logic [15:0]                     gen_count
);

  localparam int AW     = BIT_WIDTH + BIT_HEIGHT;
  localparam int CELLS  = 1 << AW;
  localparam int WIDTH  = 1 << BIT_WIDTH;
  localparam int HEIGHT = 1 << BIT_HEIGHT;
  localparam int FCW    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_GEN - 1);
  localparam logic [AW-1:0]  IDX_LAST   = AW'(CELLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_COMMIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CELLS-1:0] r_disp;
  logic [CELLS-1:0] r_work;
  logic [AW-1:0]    r_idx;
  logic [FCW-1:0]   r_frame_cnt;
  logic [15:0]      r_gen_count;

  logic                  w_tick_run;
  logic                  w_gen_trig;
  logic [BIT_HEIGHT-1:0] w_row;
  logic [BIT_WIDTH-1:0]  w_col;
  logic [3:0]            w_nbr_cnt;
  logic                  w_alive;
  logic                  w_next_cell;

  assign w_tick_run = frame_tick & run;
  assign w_gen_trig = (r_state == ST_IDLE) & w_tick_run & (r_frame_cnt == FRAME_LAST);

  assign w_row = r_idx[AW-1:BIT_WIDTH];
  assign w_col = r_idx[BIT_WIDTH-1:0];

  // Count live 8-connected neighbours of cell idx; positions off the board are dead.
  always_comb begin
    int            nr;
    int            nc;
    logic [AW-1:0] nb_addr;
    w_nbr_cnt = 4'd0;
    nr        = 0;
    nc        = 0;
    nb_addr   = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          nr = int'(w_row) + dr;
          nc = int'(w_col) + dc;
          if (nr >= 0 && nr < HEIGHT && nc >= 0 && nc < WIDTH) begin
            nb_addr   = AW'(nr * WIDTH + nc);
            w_nbr_cnt = w_nbr_cnt + {3'b000, r_disp[nb_addr]};
          end
        end
      end
    end
  end

  assign w_alive     = r_disp[r_idx];
  assign w_next_cell = (w_nbr_cnt == 4'd3) | (w_alive & (w_nbr_cnt == 4'd2));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; load overrides everything, including a coincident trigger.
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_gen_trig) w_state_nxt = ST_COMPUTE;
        ST_COMPUTE: if (r_idx == IDX_LAST) w_state_nxt = ST_COMMIT;
        ST_COMMIT:  w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Board, cell index, frame counter and generation counter updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp      <= SEED;
      r_work      <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_gen_count <= 16'd0;
    end else if (load) begin
      r_disp      <= SEED;
      r_work      <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_gen_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick_run) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt <= '0;
              r_idx       <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          // Reads come only from disp, so writing work in place is safe.
          r_work[r_idx] <= w_next_cell;
          r_idx         <= r_idx + 1'b1;
        end
        ST_COMMIT: begin
          r_disp      <= r_work;
          r_gen_count <= r_gen_count + 16'd1;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign rd_data   = r_disp[rd_addr];
  assign busy      = (r_state != ST_IDLE);
  // A load arriving during COMMIT cancels the commit, so it must also cancel the pulse.
  assign gen_done  = (r_state == ST_COMMIT) & ~load;
  assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of life_engine on three seeds run side by side
// (horizontal blinker, corner block, top-edge blinker), all with two frames per generation.
`timescale 1ns/1ps
module tb_life_engine;

  localparam logic [63:0] SEED_BLINK = 64'h0000_0000_0000_0E00;  // {9,10,11}
  localparam logic [63:0] VERT_BLINK = 64'h0000_0000_0004_0404;  // {2,10,18}
  localparam logic [63:0] SEED_BLOCK = 64'h0000_0000_0000_0303;  // {0,1,8,9}
  localparam logic [63:0] SEED_EDGE  = 64'h0000_0000_0000_0007;  // {0,1,2}
  localparam logic [63:0] EDGE_GEN1  = 64'h0000_0000_0000_0202;  // {1,9}
  localparam logic [63:0] EMPTY      = 64'h0;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run        = 1'b0;
  logic       load       = 1'b0;
  logic [5:0] rd_addr    = 6'd0;

  logic        b_rd, b_busy, b_gd;
  logic [15:0] b_gc;
  logic        k_rd, k_busy, k_gd;
  logic [15:0] k_gc;
  logic        e_rd, e_busy, e_gd;
  logic [15:0] e_gc;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  life_engine #(.FRAMES_PER_GEN(2), .SEED(SEED_BLINK)) u_blink (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .load(load),
    .rd_addr(rd_addr), .rd_data(b_rd), .busy(b_busy), .gen_done(b_gd), .gen_count(b_gc));

  life_engine #(.FRAMES_PER_GEN(2), .SEED(SEED_BLOCK)) u_block (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .load(load),
    .rd_addr(rd_addr), .rd_data(k_rd), .busy(k_busy), .gen_done(k_gd), .gen_count(k_gc));

  life_engine #(.FRAMES_PER_GEN(2), .SEED(SEED_EDGE)) u_edge (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .load(load),
    .rd_addr(rd_addr), .rd_data(e_rd), .busy(e_busy), .gen_done(e_gd), .gen_count(e_gc));

  always #5 clk = ~clk;

  // Count cycles in which the blinker instance held gen_done high.
  always @(posedge clk) if (b_gd) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_boards(output logic [63:0] b, output logic [63:0] k, output logic [63:0] e);
    b = '0; k = '0; e = '0;
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      #0.001;
      b[i] = b_rd;
      k[i] = k_rd;
      e[i] = e_rd;
    end
  endtask

  task automatic chk_boards(input string tag, input logic [63:0] xb, input logic [63:0] xk,
                            input logic [63:0] xe);
    logic [63:0] b, k, e;
    read_boards(b, k, e);
    chk({tag, "_blink"}, b, xb);
    chk({tag, "_block"}, k, xk);
    chk({tag, "_edge"}, e, xe);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic run_gen();
    tick();
    tick();
    repeat (65) @(negedge clk);
  endtask

  initial begin
    int busy_seen;
    int p0;

    // Reset values, held before any release.
    #12;
    chk("rst_busy", 64'(b_busy), 64'd0);
    chk("rst_gen_done", 64'(b_gd), 64'd0);
    chk("rst_gen_count", 64'(b_gc), 64'd0);
    chk_boards("rst", SEED_BLINK, SEED_BLOCK, SEED_EDGE);
    @(negedge clk) reset = 1'b0;
    run = 1'b1;

    // First generation with exact latency checks.
    tick();
    chk("idle_after_one_tick", 64'(b_busy), 64'd0);
    tick();
    chk("busy_compute", 64'(b_busy), 64'd1);
    repeat (64) @(negedge clk);
    chk("commit_gen_done", 64'(b_gd), 64'd1);
    chk("commit_busy", 64'(b_busy), 64'd1);
    chk_boards("disp_stable_compute", SEED_BLINK, SEED_BLOCK, SEED_EDGE);
    @(negedge clk);
    chk_boards("gen1", VERT_BLINK, SEED_BLOCK, EDGE_GEN1);
    chk("gen1_count", 64'(b_gc), 64'd1);
    chk("gen1_busy", 64'(b_busy), 64'd0);
    chk("gen1_gen_done_low", 64'(b_gd), 64'd0);
    chk("gen1_pulses", 64'(pulses), 64'd1);

    // Ticks arriving during COMPUTE must not count toward the next generation.
    tick();
    tick();
    repeat (10) @(negedge clk);
    tick();
    repeat (53) @(negedge clk);
    chk("gen2_count", 64'(b_gc), 64'd2);
    chk_boards("gen2", SEED_BLINK, SEED_BLOCK, EMPTY);
    tick();
    chk("compute_tick_ignored", 64'(b_busy), 64'd0);
    tick();
    chk("gen3_trigger", 64'(b_busy), 64'd1);
    repeat (65) @(negedge clk);
    chk_boards("gen3", VERT_BLINK, SEED_BLOCK, EMPTY);

    // Block stays put across further generations.
    run_gen();
    chk_boards("gen4", SEED_BLINK, SEED_BLOCK, EMPTY);
    run_gen();
    chk_boards("gen5", VERT_BLINK, SEED_BLOCK, EMPTY);
    chk("gen5_count_block", 64'(k_gc), 64'd5);

    // Freeze with run=0: frame_cnt held at 1 across 100 ignored ticks.
    tick();
    run = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b_busy) busy_seen++;
    end
    chk("frozen_busy_seen", 64'(busy_seen), 64'd0);
    chk("frozen_count", 64'(b_gc), 64'd5);
    chk_boards("frozen", VERT_BLINK, SEED_BLOCK, EMPTY);
    run = 1'b1;
    tick();
    chk("resume_held_cnt", 64'(b_busy), 64'd1);
    repeat (65) @(negedge clk);
    chk("gen6_count", 64'(b_gc), 64'd6);
    chk_boards("gen6", SEED_BLINK, SEED_BLOCK, EMPTY);

    // Load ten cycles into COMPUTE aborts the generation.
    p0 = pulses;
    tick();
    tick();
    repeat (9) @(negedge clk);
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    chk("load_busy", 64'(b_busy), 64'd0);
    chk("load_count", 64'(b_gc), 64'd0);
    chk("load_gen_done", 64'(b_gd), 64'd0);
    chk_boards("load", SEED_BLINK, SEED_BLOCK, SEED_EDGE);
    repeat (70) @(negedge clk);
    chk("load_no_pulse", 64'(pulses), 64'(p0));
    chk("load_no_resume", 64'(b_gc), 64'd0);

    // Load coincident with a generation-triggering tick wins.
    tick();
    @(negedge clk) begin frame_tick = 1'b1; load = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; load = 1'b0; end
    chk("load_vs_trigger_busy", 64'(b_busy), 64'd0);
    tick();
    chk("load_cleared_frame_cnt", 64'(b_busy), 64'd0);
    tick();
    chk("post_load_trigger", 64'(b_busy), 64'd1);
    repeat (65) @(negedge clk);
    chk("post_load_count", 64'(b_gc), 64'd1);
    chk_boards("post_load", VERT_BLINK, SEED_BLOCK, EDGE_GEN1);

    // Asynchronous reset mid-COMPUTE, observed before any clock edge.
    tick();
    tick();
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(b_busy), 64'd0);
    chk("async_rst_gen_done", 64'(b_gd), 64'd0);
    chk("async_rst_count", 64'(b_gc), 64'd0);
    chk_boards("async_rst", SEED_BLINK, SEED_BLOCK, SEED_EDGE);
    @(negedge clk) reset = 1'b0;
    tick();
    repeat (70) @(negedge clk);
    chk("rst_partial_discarded", 64'(b_gc), 64'd0);
    chk("rst_one_tick_idle", 64'(b_busy), 64'd0);
    tick();
    chk("rst_full_ticks_trigger", 64'(b_busy), 64'd1);
    repeat (65) @(negedge clk);
    chk("rst_first_commit", 64'(b_gc), 64'd1);
    chk_boards("rst_gen1", VERT_BLINK, SEED_BLOCK, EDGE_GEN1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 3, meaning log2 of board width in cells.
REQ-002 SHALL have parameter BIT_HEIGHT, default 3, meaning log2 of board height in cells.
REQ-003 SHALL have parameter FRAMES_PER_GEN, default 60, meaning frame ticks per generation step (minimum 1).
REQ-004 SHALL have parameter SEED, default 64'h0000_0000_0000_0008, meaning initial board, bit n = cell n.
REQ-005 SHALL have port clk  input  1  system clock; the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame, synchronous to clk.
REQ-008 SHALL have port run  input  1  level; 1 = advance generations, 0 = freeze.
REQ-009 SHALL have port load  input  1  one-cycle pulse; reload SEED.
REQ-010 SHALL have port rd_addr  input  BIT_WIDTH+BIT_HEIGHT  renderer cell address, row*width+col.
REQ-011 SHALL have port rd_data  output  1  displayed state of cell rd_addr, combinational.
REQ-012 SHALL have port busy  output  1  high while a generation is being computed.
REQ-013 SHALL have port gen_done  output  1  one-cycle pulse when a new generation is committed.
REQ-014 SHALL have port gen_count  output  16  generations committed since reset/load, wraps 65535->0.

Function
REQ-015 SHALL hold two boards of 2^(BIT_WIDTH+BIT_HEIGHT) bits: disp (read by rd_data) and work (scratch).
REQ-016 SHALL implement states IDLE, COMPUTE, COMMIT.
REQ-017 IDLE: frame_tick with run=1 increments frame_cnt; frame_tick when frame_cnt==FRAMES_PER_GEN-1 clears frame_cnt, clears idx, enters COMPUTE.
REQ-018 IDLE with run=0: frame_cnt holds; frame_tick ignored.
REQ-019 COMPUTE: each cycle writes work[idx] = next state of cell idx computed from disp only, then idx increments; at idx==last cell enters COMMIT.
REQ-020 Next-state rule: live cell survives with 2 or 3 live neighbours; dead cell born with exactly 3; otherwise dead.
REQ-021 Neighbours: 8-connected, no wrap-around; off-board positions count as dead; count held in 4 bits.
REQ-022 COMMIT: disp <= work, gen_count increments, gen_done=1 for that cycle, return to IDLE.
REQ-023 Latency: disp changes exactly 2^(BIT_WIDTH+BIT_HEIGHT)+1 cycles after the triggering frame_tick edge (65 for defaults).
REQ-024 disp SHALL not change during COMPUTE; rd_data never shows a partial generation.
REQ-025 busy SHALL be 1 in COMPUTE and COMMIT, 0 in IDLE.
REQ-026 frame_tick during COMPUTE/COMMIT SHALL be ignored and not counted.
REQ-027 run falling during COMPUTE SHALL not abort; generation completes and commits.
REQ-028 load SHALL have highest priority in any state: disp <= SEED, work <= 0, gen_count <= 0, frame_cnt <= 0, state IDLE, no gen_done pulse.
REQ-029 load coincident with a generation-triggering frame_tick: load wins, no COMPUTE entered.

Reset
REQ-030 reset SHALL asynchronously set disp=SEED, work=0, state=IDLE, idx=0, frame_cnt=0, gen_count=0, busy=0, gen_done=0.
REQ-031 reset asserted mid-COMPUTE SHALL discard the partial generation; first commit after release requires a full FRAMES_PER_GEN ticks.

Verification
REQ-032 FRAMES_PER_GEN=2, SEED cells {9,10,11}, run=1, two frame_ticks -> 65 cycles later disp={2,10,18}, gen_done pulses once, gen_count=1.
REQ-033 SEED {0,1,8,9} (corner block), run=1, 5 generations -> disp unchanged each commit, gen_count=5.
REQ-034 SEED {0,1,2} (top-edge blinker) -> after one generation disp={1,9} only (cell 57 remains 0, proving no wrap).
REQ-035 load pulsed 10 cycles into COMPUTE -> next cycle busy=0, disp=SEED, gen_count=0, no gen_done.
REQ-036 run=0 with 100 frame_ticks -> busy never asserts, disp and gen_count unchanged; run=1 resumes from held frame_cnt.
REQ-037 reset asserted mid-COMPUTE -> outputs immediately at REQ-030 values without a clock edge.
